i2c_mpu_responder: RTL and testbench

// - I2C target (slave) model of the MPU6050 side of the gyroscope bus: answers the gyroscope

---
 rtl/i2c_mpu_responder.sv | 235 +++++++++++++++++++++++
 tb/tb_i2c_mpu_responder.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_mpu_responder.sv
// i2c_mpu_responder: I2C target model of the MPU6050 end of the gyroscope bus.
// It oversamples SCL/SDA on clk, answers DEV_ADDR and serves register-pointer and
// read transactions from a 2**ADDR_W x 8 register file. SDA is driven open-drain:
// the block only ever pulls SDA low (sda_oe=1) or releases it.
// Optional feature macro: I2C_RESP_WRITE_EN. When it is defined, bus data bytes
// after the pointer byte are ACKed and written to the register file. When it is
// not defined, those bytes are not ACKed and the register file can only be
// written through the cfg_* port.
`timescale 1ns/1ps

module i2c_mpu_responder #(
  parameter logic [6:0] DEV_ADDR    = 7'h68,
  parameter int         ADDR_W      = 4,
  parameter int         SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              scl_in,
  input  logic              sda_in,
  output logic              sda_oe,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [7:0]        cfg_data,
  output logic              busy,
  output logic              rd_strobe,
  output logic              nack_seen
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_ADDR      = 4'd1;
  localparam logic [3:0] S_ADDR_ACK  = 4'd2;
  localparam logic [3:0] S_PTR       = 4'd3;
  localparam logic [3:0] S_PTR_ACK   = 4'd4;
  localparam logic [3:0] S_WDATA     = 4'd5;
  localparam logic [3:0] S_WDATA_ACK = 4'd6;
  localparam logic [3:0] S_TX        = 4'd7;
  localparam logic [3:0] S_TX_ACK    = 4'd8;
  localparam logic [3:0] S_WAIT      = 4'd9;

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_s;
  logic                   sda_s;
  logic                   scl_q;
  logic                   sda_q;
  logic                   scl_rise;
  logic                   scl_fall;
  logic                   start_det;
  logic                   stop_det;

  logic [3:0]        state;
  logic [2:0]        bit_cnt;
  logic [6:0]        rx_sh;
  logic [7:0]        rx_byte;
  logic              rw;
  logic              ack_drv;
  logic [7:0]        tx_sh;
  logic [3:0]        tx_cnt;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] ptr_inc;
  logic [7:0]        regs [DEPTH];

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_q;
  assign scl_fall  = ~scl_s & scl_q;
  // SDA edges only count as START/STOP when SCL was high on both samples.
  assign start_det = scl_s & scl_q & sda_q & ~sda_s;
  assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;
  assign rx_byte   = {rx_sh, sda_s};
  assign ptr_inc   = ptr + 1'b1;

  // Input synchronisers and one-clk history for edge detection. Deliberately not
  // reset, so a reset in the middle of a transfer cannot fabricate a START.
  always_ff @(posedge clk) begin
    scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
    sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
    scl_q    <= scl_s;
    sda_q    <= sda_s;
  end

  // Bus protocol FSM: byte reception, ACK slots, byte transmission and pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      sda_oe    <= 1'b0;
      rd_strobe <= 1'b0;
      nack_seen <= 1'b0;
      ptr       <= '0;
      bit_cnt   <= 3'd0;
      ack_drv   <= 1'b0;
      tx_cnt    <= 4'd0;
    end else begin
      rd_strobe <= 1'b0;
      nack_seen <= 1'b0;
      if (start_det) begin
        state   <= S_ADDR;
        bit_cnt <= 3'd0;
        sda_oe  <= 1'b0;
        ack_drv <= 1'b0;
      end else if (stop_det) begin
        state   <= S_IDLE;
        sda_oe  <= 1'b0;
        ack_drv <= 1'b0;
      end else begin
        case (state)
          S_ADDR: begin
            if (scl_rise) begin
              rx_sh   <= rx_byte[6:0];
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                rw <= rx_byte[0];
                // A foreign address parks in WAIT without ever touching SDA.
                state <= (rx_byte[7:1] == DEV_ADDR) ? S_ADDR_ACK : S_WAIT;
              end
            end
          end
          S_ADDR_ACK: begin
            if (scl_fall) begin
              if (!ack_drv) begin
                sda_oe  <= 1'b1;
                ack_drv <= 1'b1;
              end else if (rw) begin
                // The fall that ends the ACK also presents the first data bit.
                ack_drv   <= 1'b0;
                tx_sh     <= {regs[ptr][6:0], 1'b0};
                sda_oe    <= ~regs[ptr][7];
                tx_cnt    <= 4'd1;
                rd_strobe <= 1'b1;
                state     <= S_TX;
              end else begin
                ack_drv <= 1'b0;
                sda_oe  <= 1'b0;
                bit_cnt <= 3'd0;
                state   <= S_PTR;
              end
            end
          end
          S_PTR: begin
            if (scl_rise) begin
              rx_sh   <= rx_byte[6:0];
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                ptr   <= rx_byte[ADDR_W-1:0];
                state <= S_PTR_ACK;
              end
            end
          end
          S_PTR_ACK, S_WDATA_ACK: begin
            if (scl_fall) begin
              if (!ack_drv) begin
                sda_oe  <= 1'b1;
                ack_drv <= 1'b1;
              end else begin
                ack_drv <= 1'b0;
                sda_oe  <= 1'b0;
                bit_cnt <= 3'd0;
                state   <= S_WDATA;
              end
            end
          end
          S_WDATA: begin
            if (scl_rise) begin
              rx_sh   <= rx_byte[6:0];
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
`ifdef I2C_RESP_WRITE_EN
                ptr   <= ptr_inc;
                state <= S_WDATA_ACK;
`else
                // No ACK slot is driven: the master sees a NACK on the data byte.
                state <= S_WAIT;
`endif
              end
            end
          end
          S_TX: begin
            if (scl_fall) begin
              if (tx_cnt == 4'd8) begin
                sda_oe <= 1'b0;
                state  <= S_TX_ACK;
              end else begin
                sda_oe <= ~tx_sh[7];
                tx_sh  <= {tx_sh[6:0], 1'b0};
                tx_cnt <= tx_cnt + 4'd1;
              end
            end
          end
          S_TX_ACK: begin
            if (scl_rise) begin
              if (!sda_s) begin
                ptr       <= ptr_inc;
                tx_sh     <= regs[ptr_inc];
                tx_cnt    <= 4'd0;
                rd_strobe <= 1'b1;
                state     <= S_TX;
              end else begin
                nack_seen <= 1'b1;
                state     <= S_WAIT;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

`ifdef I2C_RESP_WRITE_EN
  logic bus_we;
  assign bus_we = ~reset & ~start_det & ~stop_det & scl_rise &
                  (state == S_WDATA) & (bit_cnt == 3'd7);
`endif

  // Register file: the local cfg port overrides a bus write to the same entry.
  always_ff @(posedge clk) begin
`ifdef I2C_RESP_WRITE_EN
    if (bus_we) regs[ptr] <= rx_byte;
`endif
    if (cfg_we) regs[cfg_addr] <= cfg_data;
  end

  // busy marks the addressed part of a transaction, from address ACK to the end.
  always_comb begin
    busy = 1'b0;
    case (state)
      S_ADDR_ACK, S_PTR, S_PTR_ACK, S_WDATA, S_WDATA_ACK, S_TX, S_TX_ACK: busy = 1'b1;
      default: busy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_i2c_mpu_responder.sv
// Bench for i2c_mpu_responder: a bit-level I2C master drives the bus, expected
// bus responses and status pulses go into queues, and a checker process pops
// and compares them as the DUT produces them. Honours I2C_RESP_WRITE_EN.
`timescale 1ns/1ps

module tb_i2c_mpu_responder;

  localparam int Q = 8;  // clk cycles per quarter SCL period
  localparam logic [7:0] TAG_ACK  = 8'hA0;
  localparam logic [7:0] TAG_BYTE = 8'hB0;
  localparam int P_RD = 1;
  localparam int P_NK = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       m_scl;
  logic       m_sda;
  logic       sda_bus;
  logic       sda_oe;
  logic       cfg_we;
  logic [3:0] cfg_addr;
  logic [7:0] cfg_data;
  logic       busy;
  logic       rd_strobe;
  logic       nack_seen;

  int n_tests = 0;
  int n_fail  = 0;
  int oe_cnt  = 0;
  int busy_cnt = 0;

  logic [15:0] exp_bus [$];
  logic [15:0] obs_bus [$];
  int          exp_pulse [$];

  always #10 clk = ~clk;

  assign sda_bus = m_sda & ~sda_oe;

  i2c_mpu_responder #(.DEV_ADDR(7'h68), .ADDR_W(4), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .scl_in   (m_scl),
    .sda_in   (sda_bus),
    .sda_oe   (sda_oe),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .busy     (busy),
    .rd_strobe(rd_strobe),
    .nack_seen(nack_seen)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  task automatic wait_q();
    repeat (Q) @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [3:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic i2c_start();
    if (m_scl == 1'b0) begin
      m_sda = 1'b1; wait_q();
      m_scl = 1'b1; wait_q();
    end
    m_sda = 1'b0; wait_q();
    m_scl = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; wait_q();
    m_scl = 1'b1; wait_q();
    m_sda = 1'b1; wait_q();
    wait_q();
  endtask

  // One SCL period; optionally fires cfg_we on the clk the DUT acts on this rise.
  task automatic bit_cyc(input logic drv, input logic collide, input logic [3:0] ca,
                         input logic [7:0] cd, output logic smp);
    m_sda = drv; wait_q();
    m_scl = 1'b1;
    if (collide) begin
      @(posedge clk); @(posedge clk); #1;
      cfg_we = 1'b1; cfg_addr = ca; cfg_data = cd;
      @(posedge clk); #1;
      cfg_we = 1'b0;
      repeat (Q - 3) @(posedge clk);
      #1;
    end else begin
      wait_q();
    end
    smp = sda_bus;
    wait_q();
    m_scl = 1'b0; wait_q();
  endtask

  task automatic write_byte_c(input logic [7:0] b, input logic exp_ack, input logic collide,
                              input logic [3:0] ca, input logic [7:0] cd);
    logic s;
    exp_bus.push_back({TAG_ACK, 7'd0, exp_ack});
    for (int i = 7; i >= 0; i--) bit_cyc(b[i], (i == 0) ? collide : 1'b0, ca, cd, s);
    bit_cyc(1'b1, 1'b0, 4'd0, 8'd0, s);
    obs_bus.push_back({TAG_ACK, 7'd0, s});
  endtask

  task automatic write_byte(input logic [7:0] b, input logic exp_ack);
    write_byte_c(b, exp_ack, 1'b0, 4'd0, 8'd0);
  endtask

  task automatic read_byte(input logic [7:0] expv, input logic mack);
    logic [7:0] v;
    logic s;
    exp_bus.push_back({TAG_BYTE, expv});
    for (int i = 7; i >= 0; i--) begin
      bit_cyc(1'b1, 1'b0, 4'd0, 8'd0, s);
      v[i] = s;
    end
    bit_cyc(~mack, 1'b0, 4'd0, 8'd0, s);
    obs_bus.push_back({TAG_BYTE, v});
  endtask

  // Full pointer-set + single-byte read transaction.
  task automatic read_reg(input logic [3:0] a, input logic [7:0] expv);
    i2c_start();
    write_byte(8'hD0, 1'b0);
    write_byte({4'h0, a}, 1'b0);
    i2c_start();
    exp_pulse.push_back(P_RD);
    write_byte(8'hD1, 1'b0);
    exp_pulse.push_back(P_NK);
    read_byte(expv, 1'b0);
    i2c_stop();
  endtask

  task automatic pop_pulse(input int kind);
    int e;
    if (exp_pulse.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_pulse: got kind %0d, expected none", kind);
    end else begin
      e = exp_pulse.pop_front();
      check("pulse_kind", kind, e);
    end
  endtask

  // Checker: compares DUT pulses and observed bus responses against expectations.
  initial begin
    logic [15:0] e;
    logic [15:0] o;
    forever begin
      @(negedge clk);
      if (sda_oe) oe_cnt++;
      if (busy) busy_cnt++;
      if (rd_strobe) pop_pulse(P_RD);
      if (nack_seen) pop_pulse(P_NK);
      while (obs_bus.size() > 0 && exp_bus.size() > 0) begin
        e = exp_bus.pop_front();
        o = obs_bus.pop_front();
        check((e[15:8] == TAG_ACK) ? "ack_bit" : "rx_byte", o, e);
      end
    end
  end

  initial begin
    int oe0;
    int busy0;
    logic [3:0] nib;
    logic s;
    m_scl = 1'b1; m_sda = 1'b1;
    reset = 1'b1; cfg_we = 1'b0; cfg_addr = 4'd0; cfg_data = 8'd0;
    repeat (5) @(posedge clk); #1;
    check("rst_sda_oe", sda_oe, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_rd_strobe", rd_strobe, 1'b0);
    check("rst_nack_seen", nack_seen, 1'b0);
    reset = 1'b0;
    repeat (5) @(posedge clk); #1;

    // Basic pointer write, repeated start, one-byte read with NACK.
    cfg_write(4'd5, 8'hF0);
    i2c_start();
    write_byte(8'hD0, 1'b0);
    check("t1_busy_addressed", busy, 1'b1);
    write_byte(8'h05, 1'b0);
    i2c_start();
    exp_pulse.push_back(P_RD);
    write_byte(8'hD1, 1'b0);
    exp_pulse.push_back(P_NK);
    read_byte(8'hF0, 1'b0);
    i2c_stop();
    check("t1_busy_after_stop", busy, 1'b0);

    // Foreign address: never ACKed, and the matching byte that follows is ignored.
    oe0 = oe_cnt; busy0 = busy_cnt;
    i2c_start();
    write_byte(8'hA0, 1'b1);
    write_byte(8'hD0, 1'b1);
    i2c_stop();
    check("t2_oe_never", oe_cnt - oe0, 0);
    check("t2_busy_never", busy_cnt - busy0, 0);

    // Burst read across the pointer wrap.
    cfg_write(4'd15, 8'h11);
    cfg_write(4'd0, 8'h22);
    cfg_write(4'd1, 8'h33);
    i2c_start();
    write_byte(8'hD0, 1'b0);
    write_byte(8'h0F, 1'b0);
    i2c_start();
    exp_pulse.push_back(P_RD);
    write_byte(8'hD1, 1'b0);
    exp_pulse.push_back(P_RD);
    read_byte(8'h11, 1'b1);
    exp_pulse.push_back(P_RD);
    read_byte(8'h22, 1'b1);
    exp_pulse.push_back(P_NK);
    read_byte(8'h33, 1'b0);
    i2c_stop();

    // Reset while the DUT is pulling SDA low for bit 3 of 0xF0.
    cfg_write(4'd7, 8'h3C);
    i2c_start();
    write_byte(8'hD0, 1'b0);
    write_byte(8'h05, 1'b0);
    i2c_start();
    exp_pulse.push_back(P_RD);
    write_byte(8'hD1, 1'b0);
    for (int i = 7; i >= 4; i--) begin
      bit_cyc(1'b1, 1'b0, 4'd0, 8'd0, s);
      nib[i-4] = s;
    end
    check("t4_upper_nibble", nib, 4'hF);
    check("t4_oe_bit3", sda_oe, 1'b1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("t4_oe_after_reset", sda_oe, 1'b0);
    check("t4_busy_after_reset", busy, 1'b0);
    reset = 1'b0;
    i2c_stop();
    read_reg(4'd7, 8'h3C);

    // Bus write of 0xAB to reg[2].
    cfg_write(4'd2, 8'h77);
    i2c_start();
    write_byte(8'hD0, 1'b0);
    write_byte(8'h02, 1'b0);
`ifdef I2C_RESP_WRITE_EN
    write_byte(8'hAB, 1'b0);
    i2c_stop();
    read_reg(4'd2, 8'hAB);
`else
    write_byte(8'hAB, 1'b1);
    i2c_stop();
    read_reg(4'd2, 8'h77);
`endif

`ifdef I2C_RESP_WRITE_EN
    // Local config write on the same clk as the bus write to reg[2].
    i2c_start();
    write_byte(8'hD0, 1'b0);
    write_byte(8'h02, 1'b0);
    write_byte_c(8'hAB, 1'b0, 1'b1, 4'd2, 8'h5A);
    i2c_stop();
    read_reg(4'd2, 8'h5A);
`endif

    repeat (20) @(posedge clk); #1;
    check("exp_bus_left", exp_bus.size(), 0);
    check("obs_bus_left", obs_bus.size(), 0);
    check("exp_pulse_left", exp_pulse.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
